block_flush_requester: RTL

BLOCK_FLUSH_REQUESTER -- requirements
Module: block_flush_requester

---
 rtl/block_flush_requester_pkg.sv | 43 ++++
 rtl/block_flush_requester_sector_priority_encoder.sv | 19 +
 rtl/block_flush_requester.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/block_flush_requester_pkg.sv
// Shared AMI request definitions: field widths, request bus layout and size codes
// used by the block flush requester.
package block_flush_requester_pkg;

  localparam int AMI_ADDR_W  = 64;
  localparam int AMI_DATA_W  = 576;
  localparam int AMI_SIZE_W  = 6;
  localparam int AMI_REQ_W   = 648;
  localparam int BLOCK_W     = 512;
  localparam int SECTOR_W    = 64;
  localparam int NUM_SECTORS = 8;

  localparam int SECTOR_BYTES = 8;
  localparam int BLOCK_BYTES  = 64;

  // A 64-byte size does not fit the 6-bit field and is carried modulo 64.
  localparam logic [AMI_SIZE_W-1:0] AMI_SIZE_SECTOR = AMI_SIZE_W'(SECTOR_BYTES);
  localparam logic [AMI_SIZE_W-1:0] AMI_SIZE_BLOCK  = AMI_SIZE_W'(BLOCK_BYTES);

  localparam logic [AMI_ADDR_W-1:0] BLOCK_OFFSET_MASK = AMI_ADDR_W'(BLOCK_BYTES - 1);

  // Packed MSB-first: size[647:642], data[641:66], addr[65:2], is_write[1], valid[0].
  typedef struct packed {
    logic [AMI_SIZE_W-1:0] size;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_ADDR_W-1:0] addr;
    logic                  is_write;
    logic                  valid;
  } ami_req_t;

  function automatic ami_req_t ami_write_req(input logic [AMI_ADDR_W-1:0] addr,
                                             input logic [AMI_DATA_W-1:0] data,
                                             input logic [AMI_SIZE_W-1:0] size);
    ami_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'b1;
    r.addr     = addr;
    r.data     = data;
    r.size     = size;
    return r;
  endfunction

endpackage

// File: rtl/block_flush_requester_sector_priority_encoder.sv
// Lowest-set-bit encoder over the 8-bit sector dirty mask.
module sector_priority_encoder
  import block_flush_requester_pkg::*;
(
  input  logic [NUM_SECTORS-1:0] mask_i,
  output logic [2:0]             idx_o,
  output logic                   any_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx_o = '0;
    any_o = |mask_i;
    for (int i = NUM_SECTORS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/block_flush_requester.sv
// Turns one flush command (block + dirty mask) into either a full-block AMI write
// or a run of per-sector AMI writes, then pulses flush_done.
module block_flush_requester
  import block_flush_requester_pkg::*;
#(
  parameter int AMI_ADDR_WIDTH     = block_flush_requester_pkg::AMI_ADDR_W,
  parameter int AMI_DATA_WIDTH     = block_flush_requester_pkg::AMI_DATA_W,
  parameter int AMI_REQ_SIZE_WIDTH = block_flush_requester_pkg::AMI_SIZE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_valid,
  output logic                      flush_ready,
  input  logic [AMI_ADDR_WIDTH-1:0] flush_addr,
  input  logic [NUM_SECTORS-1:0]    flush_dirty,
  input  logic [BLOCK_W-1:0]        block_data,
  output logic [2+AMI_ADDR_WIDTH+AMI_DATA_WIDTH+AMI_REQ_SIZE_WIDTH-1:0] req_out,
  input  logic                      req_ready,
  output logic                      flush_done
);

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    SECTOR,
    DONE
  } state_e;

  state_e                 state_q;
  logic [AMI_ADDR_W-1:0]  base_q;
  logic [NUM_SECTORS-1:0] mask_q;
  logic [BLOCK_W-1:0]     data_q;
  logic [2:0]             idx_q;
  ami_req_t               req_q;
  logic                   flush_done_q;
  logic                   flush_ready_q;

  logic [AMI_ADDR_W-1:0]  addr_base;
  logic [NUM_SECTORS-1:0] mask_clr;
  logic [NUM_SECTORS-1:0] enc_mask;
  logic [AMI_ADDR_W-1:0]  sector_base;
  logic [BLOCK_W-1:0]     sector_src;
  logic [SECTOR_W-1:0]    sector_word;
  logic [2:0]             enc_idx;
  logic                   enc_any;
  ami_req_t               sector_req;
  ami_req_t               full_req;
  logic                   accept;

  assign addr_base = flush_addr & ~BLOCK_OFFSET_MASK;
  assign mask_clr  = mask_q & ~(NUM_SECTORS'(1) << idx_q);
  assign accept    = flush_valid && flush_ready_q;

  // In IDLE the next request is built straight from the inputs being accepted;
  // afterwards it comes from the latched copy with the serviced bit removed.
  always_comb begin
    enc_mask    = mask_clr;
    sector_base = base_q;
    sector_src  = data_q;
    if (state_q == IDLE) begin
      enc_mask    = flush_dirty;
      sector_base = addr_base;
      sector_src  = block_data;
    end
  end

  sector_priority_encoder u_enc (
    .mask_i (enc_mask),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  assign sector_word = sector_src[{enc_idx, 6'b0} +: SECTOR_W];
  assign sector_req  = ami_write_req(sector_base + {{(AMI_ADDR_W-6){1'b0}}, enc_idx, 3'b0},
                                     {{(AMI_DATA_W-SECTOR_W){1'b0}}, sector_word},
                                     AMI_SIZE_SECTOR);
  assign full_req    = ami_write_req(addr_base,
                                     {{(AMI_DATA_W-BLOCK_W){1'b0}}, block_data},
                                     AMI_SIZE_BLOCK);

  // NOTE: state and registered outputs share one clocked block and use only <=,
  // so every register sees the values from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      mask_q        <= '0;
      // NOTE: the wide block copy is reset on purpose; it is a register bank, not a RAM.
      data_q        <= '0;
      idx_q         <= '0;
      req_q         <= '0;
      flush_done_q  <= 1'b0;
      flush_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q        <= addr_base;
            mask_q        <= flush_dirty;
            data_q        <= block_data;
            idx_q         <= enc_idx;
            flush_ready_q <= 1'b0;
            if (flush_dirty == '1) begin
              state_q <= FULL;
              req_q   <= full_req;
            end else if (flush_dirty == '0) begin
              state_q      <= DONE;
              flush_done_q <= 1'b1;
            end else begin
              state_q <= SECTOR;
              req_q   <= sector_req;
            end
          end else begin
            flush_ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (req_ready) begin
            state_q      <= DONE;
            req_q        <= '0;
            flush_done_q <= 1'b1;
          end
        end
        SECTOR: begin
          if (req_ready) begin
            mask_q <= mask_clr;
            if (enc_any) begin
              idx_q <= enc_idx;
              req_q <= sector_req;
            end else begin
              state_q      <= DONE;
              req_q        <= '0;
              flush_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q       <= IDLE;
          flush_done_q  <= 1'b0;
          flush_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_out     = req_q;
  assign flush_ready = flush_ready_q;
  assign flush_done  = flush_done_q;

endmodule
